// File: rtl/real_pkg.sv
// Shared constants, operand classes, flag indices and FSM states for the
// floating-point divider datapath.
package real_pkg;

   localparam int EXP_W  = 8;
   localparam int MANT_W = 23;
   localparam int WIDTH  = 1 + EXP_W + MANT_W;
   localparam int BIAS   = (1 << (EXP_W - 1)) - 1;

   localparam logic [WIDTH-1:0] QNAN = 32'h7FC0_0000;

   localparam int FLAG_INVALID   = 4;
   localparam int FLAG_DIV_ZERO  = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

   typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, DONE} state_e;

   // Denormals land in ZERO, which is how inputs get flushed to zero.
   function automatic fp_class_e classify(input logic exp_zero,
                                          input logic exp_ones,
                                          input logic frac_zero);
      if (exp_zero)
         return ZERO;
      else if (exp_ones)
         return frac_zero ? INF : NAN;
      else
         return NORM;
   endfunction

endpackage

// File: rtl/real_div_mant_divider.sv
// Iterative restoring mantissa divider: one quotient bit per cycle, producing
// the integer quotient bits followed by guard and round, plus a sticky bit.
module mant_divider #(
   parameter int MANT_W = 23
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [MANT_W+1:0] dividend,
   input  logic [MANT_W:0]   divisor,
   output logic              busy,
   output logic              done,
   output logic [MANT_W:0]   quot,
   output logic              guard,
   output logic              round,
   output logic              sticky
);

   localparam int STEPS = MANT_W + 3;
   localparam int CNT_W = $clog2(STEPS + 1);

   logic [MANT_W+2:0] rem_q, rem_d, q_q, q_d, rem_sel;
   logic [MANT_W:0]   div_q, div_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              ge;

   always_comb begin
      ge      = rem_q >= {2'b00, div_q};
      rem_sel = ge ? (rem_q - {2'b00, div_q}) : rem_q;
      rem_d   = rem_q;
      div_d   = div_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      if (start) begin
         rem_d  = {1'b0, dividend};
         div_d  = divisor;
         q_d    = '0;
         cnt_d  = CNT_W'(STEPS);
         busy_d = 1'b1;
      end else if (busy_q) begin
         q_d    = {q_q[MANT_W+1:0], ge};
         rem_d  = rem_sel << 1;
         cnt_d  = cnt_q - CNT_W'(1);
         busy_d = (cnt_q != CNT_W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q  <= '0;
         div_q  <= '0;
         q_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         div_q  <= div_d;
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   // done marks the cycle whose closing edge computes the last quotient bit.
   assign done   = busy_q && (cnt_q == CNT_W'(1));
   assign busy   = busy_q;
   assign quot   = q_q[MANT_W+2:2];
   assign guard  = q_q[1];
   assign round  = q_q[0];
   assign sticky = |rem_q;

endmodule

// File: rtl/real_div.sv
// Iterative IEEE754 divider with valid/ready on both sides, FTZ in and out.
// Define REAL_DIV_ROUND_NE_EN for round-to-nearest-even; default truncates.
module real_div #(
   parameter int EXP_W  = real_pkg::EXP_W,
   parameter int MANT_W = real_pkg::MANT_W,
   parameter int WIDTH  = real_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] res,
   output logic [4:0]       flags,
   output logic             out_valid,
   input  logic             out_ready
);
   import real_pkg::*;

   localparam int E_W = EXP_W + 2;
   localparam logic signed [E_W-1:0] E_BIAS = E_W'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);

   state_e                state_q, state_d;
   logic [WIDTH-1:0]      a_q, a_d, b_q, b_d, res_q, res_d;
   logic [4:0]            flags_q, flags_d;
   logic signed [E_W-1:0] exp_q, exp_d, exp_unp, exp_r;

   logic [EXP_W-1:0]  ea, eb;
   logic [MANT_W-1:0] fa, fb, frac_r;
   logic [MANT_W:0]   ma, mb, quot;
   logic [MANT_W+1:0] dividend, mant_r;
   fp_class_e         ca, cb;
   logic              s_ab, a_lt_b, inc, inexact;
   logic              div_start, div_busy, div_done, guard, round_b, sticky;
   logic [WIDTH-1:0]  inf_w, zero_w, qnan_w;

   // Operand unpacking and the rounding datapath; both read held registers.
   always_comb begin
      s_ab     = a_q[WIDTH-1] ^ b_q[WIDTH-1];
      ea       = a_q[WIDTH-2:MANT_W];
      eb       = b_q[WIDTH-2:MANT_W];
      fa       = a_q[MANT_W-1:0];
      fb       = b_q[MANT_W-1:0];
      ca       = classify(ea == '0, &ea, fa == '0);
      cb       = classify(eb == '0, &eb, fb == '0);
      ma       = {1'b1, fa};
      mb       = {1'b1, fb};
      a_lt_b   = ma < mb;
      dividend = a_lt_b ? {ma, 1'b0} : {1'b0, ma};
      exp_unp  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS
                 - $signed({{(E_W-1){1'b0}}, a_lt_b});
      inf_w    = {s_ab, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      zero_w   = {s_ab, {(WIDTH-1){1'b0}}};
      qnan_w   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
`ifdef REAL_DIV_ROUND_NE_EN
      inc      = guard & (round_b | sticky | quot[0]);
`else
      inc      = 1'b0;
`endif
      mant_r   = {1'b0, quot} + {{(MANT_W+1){1'b0}}, inc};
      exp_r    = exp_q + $signed({{(E_W-1){1'b0}}, mant_r[MANT_W+1]});
      frac_r   = mant_r[MANT_W+1] ? mant_r[MANT_W:1] : mant_r[MANT_W-1:0];
      inexact  = guard | round_b | sticky;
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      exp_d     = exp_q;
      res_d     = res_q;
      flags_d   = flags_q;
      div_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            flags_d = '0;
            state_d = DONE;
            if (ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) ||
                (ca == INF && cb == INF)) begin
               res_d                 = qnan_w;
               flags_d[FLAG_INVALID] = 1'b1;
            end else if (cb == ZERO) begin
               res_d                  = inf_w;
               flags_d[FLAG_DIV_ZERO] = 1'b1;
            end else if (ca == INF) begin
               res_d = inf_w;
            end else if (ca == ZERO || cb == INF) begin
               res_d = zero_w;
            end else begin
               exp_d     = exp_unp;
               div_start = !div_busy;
               state_d   = ITER;
            end
         end
         ITER: begin
            if (div_done)
               state_d = ROUND;
         end
         ROUND: begin
            flags_d = '0;
            state_d = DONE;
            if (exp_r >= E_MAX) begin
               res_d                   = inf_w;
               flags_d[FLAG_OVERFLOW]  = 1'b1;
               flags_d[FLAG_INEXACT]   = 1'b1;
            end else if (exp_r[E_W-1] || exp_r == '0) begin
               res_d                   = zero_w;
               flags_d[FLAG_UNDERFLOW] = 1'b1;
               flags_d[FLAG_INEXACT]   = 1'b1;
            end else begin
               res_d                 = {s_ab, exp_r[EXP_W-1:0], frac_r};
               flags_d[FLAG_INEXACT] = inexact;
            end
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         exp_q   <= '0;
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         exp_q   <= exp_d;
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

   mant_divider #(.MANT_W(MANT_W)) u_mant_divider (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend (dividend),
      .divisor  (mb),
      .busy     (div_busy),
      .done     (div_done),
      .quot     (quot),
      .guard    (guard),
      .round    (round_b),
      .sticky   (sticky)
   );

   // Outputs are forced quiet for as long as reset is held.
   assign in_ready  = (state_q == IDLE) && !reset;
   assign out_valid = (state_q == DONE) && !reset;
   assign res       = reset ? '0 : res_q;
   assign flags     = reset ? '0 : flags_q;

endmodule

// File: tb/tb_real_div.sv
// Self-checking bench for real_div: directed corner cases plus random operands
// compared against an integer-arithmetic reference of the division rules.
module tb_real_div;
   import real_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] op_a, op_b;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] res;
   logic [4:0]  flags;
   logic        out_valid;
   logic        out_ready;

   int assertions = 0;
   int failures   = 0;

   real_div dut (
      .clk       (clk),
      .reset     (reset),
      .op_a      (op_a),
      .op_b      (op_b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .res       (res),
      .flags     (flags),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      assertions++;
      if (got !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
      end
   endtask

   // Reference: exact quotient from long integer division, then rounding.
   function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [4:0] f,
                                    output int lat);
      logic              s;
      int                ea, eb, e, drop;
      longint unsigned   ma, mb, num, q, rem, mant, lost, half;
      bit                nanA, nanB, infA, infB, zA, zB, inexact;
      s    = a[31] ^ b[31];
      ea   = int'(a[30:23]);
      eb   = int'(b[30:23]);
      nanA = (ea == 255) && (a[22:0] != 0);
      nanB = (eb == 255) && (b[22:0] != 0);
      infA = (ea == 255) && (a[22:0] == 0);
      infB = (eb == 255) && (b[22:0] == 0);
      zA   = (ea == 0);
      zB   = (eb == 0);
      f    = 5'b00000;
      lat  = 2;
      if (nanA || nanB || (zA && zB) || (infA && infB)) begin
         r = QNAN;
         f = 5'b10000;
      end else if (zB) begin
         r = {s, 8'hFF, 23'h0};
         f = 5'b01000;
      end else if (infA) begin
         r = {s, 8'hFF, 23'h0};
      end else if (zA || infB) begin
         r = {s, 31'h0};
      end else begin
         lat  = 29;
         ma   = 64'({1'b1, a[22:0]});
         mb   = 64'({1'b1, b[22:0]});
         num  = ma << 26;
         q    = num / mb;
         rem  = num % mb;
         e    = ea - eb + 127;
         if (q >= (64'd1 << 26)) drop = 3;
         else begin
            drop = 2;
            e    = e - 1;
         end
         mant    = q >> drop;
         lost    = q & ((64'd1 << drop) - 1);
         half    = 64'd1 << (drop - 1);
         inexact = (lost != 0) || (rem != 0);
`ifdef REAL_DIV_ROUND_NE_EN
         if (lost > half || (lost == half && (rem != 0 || mant[0]))) mant = mant + 1;
`else
         if (half == 0) mant = mant + 1;
`endif
         if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
         end
         if (e >= 255) begin
            r = {s, 8'hFF, 23'h0};
            f = 5'b00101;
         end else if (e <= 0) begin
            r = {s, 31'h0};
            f = 5'b00011;
         end else begin
            r = {s, e[7:0], mant[22:0]};
            f = {4'b0000, inexact};
         end
      end
   endfunction

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [4:0] f, output int lat);
      int waitCnt = 0;
      while (!in_ready && waitCnt < 50) begin
         step();
         waitCnt++;
      end
      if (!in_ready) checkOutput("in_ready wait", 32'(in_ready), 32'd1);
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         step();
         lat++;
      end
      r         = res;
      f         = flags;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic directedCase(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input logic [4:0] expFlags, input int expLat);
      logic [31:0] r;
      logic [4:0]  f;
      int          lat;
      applyStimulus(a, b, r, f, lat);
      checkOutput({tag, " res"}, r, expRes);
      checkOutput({tag, " flags"}, {27'b0, f}, {27'b0, expFlags});
      checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
   endtask

   function automatic logic [31:0] randOperand();
      logic s;
      s = 1'($urandom);
      case ($urandom_range(0, 11))
         0:       return {s, 31'h0};
         1:       return {s, 8'hFF, 23'h0};
         2:       return {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
         3:       return {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
         default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
      endcase
   endfunction

   initial begin
      logic [31:0] r0, er, ra, rb;
      logic [4:0]  f0, ef;
      int          el, waitCnt, seen;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_a      = '0;
      op_b      = '0;
      step();
      step();
      checkOutput("reset res", res, 32'h0);
      checkOutput("reset flags", {27'b0, flags}, 32'h0);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      step();
      checkOutput("in_ready after reset", 32'(in_ready), 32'd1);

      directedCase("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29);
`ifdef REAL_DIV_ROUND_NE_EN
      directedCase("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29);
`else
      directedCase("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 5'b00001, 29);
`endif
      directedCase("1/0", 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2);
      directedCase("0/0", 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2);
      directedCase("-inf/2", 32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 2);
      directedCase("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 29);
      directedCase("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 29);

      // Backpressure: result must hold and nothing new may be accepted.
      op_a     = 32'h40C00000;
      op_b     = 32'h40000000;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      waitCnt  = 0;
      while (!out_valid && waitCnt < 100) begin
         step();
         waitCnt++;
      end
      r0 = res;
      f0 = flags;
      checkOutput("bp res", r0, 32'h40400000);
      op_a     = 32'h3F800000;
      op_b     = 32'h40400000;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("bp res stable", res, r0);
         checkOutput("bp flags stable", {27'b0, flags}, {27'b0, f0});
         checkOutput("bp in_ready low", 32'(in_ready), 32'd0);
         checkOutput("bp out_valid held", 32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checkOutput("bp in_ready after release", 32'(in_ready), 32'd1);
      checkOutput("bp out_valid after release", 32'(out_valid), 32'd0);

      // Reset during the tenth divide iteration aborts the operation.
      op_a     = 32'h40C00000;
      op_b     = 32'h40000000;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) step();
      reset = 1'b1;
      step();
      checkOutput("abort out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort res", res, 32'h0);
      checkOutput("abort flags", {27'b0, flags}, 32'h0);
      reset = 1'b0;
      seen  = 0;
      for (int i = 0; i < 35; i++) begin
         step();
         if (out_valid) seen++;
      end
      checkOutput("abort no result", 32'(seen), 32'd0);
      checkOutput("abort res after release", res, 32'h0);
      directedCase("6/2 after abort", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29);

      for (int i = 0; i < 60; i++) begin
         ra = randOperand();
         rb = randOperand();
         refModel(ra, rb, er, ef, el);
         directedCase("random", ra, rb, er, ef, el);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
